snoop_bus: RTL and testbench

Shared snooping bus for the MOESI multicore cache system. It arbitrates round-robin among the per-core L1 controller bus request channels and broadcasts snoops to the peer L1 caches. It obtains data either cache-to-cache or from the L2 controller, then returns the response to the requesting core. Only one transaction is in flight at a time; the bus is atomic.

---
 rtl/snoop_bus.sv | 230 +++++++++++++++++++++++
 tb/tb_snoop_bus.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus.sv
// snoop_bus: atomic round-robin snooping bus between the MOESI L1s and L2.
// Define SNOOP_BUS_STATS_EN to add the txn_count/c2c_count counters.
module snoop_bus #(
    parameter int CPU_CORES = 4,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CPU_CORES-1:0]         req_valid,
    output logic [CPU_CORES-1:0]         req_ready,
    input  logic [CPU_CORES*ADDR_W-1:0]  req_addr,
    input  logic [CPU_CORES*2-1:0]       req_type,
    input  logic [CPU_CORES*DATA_W-1:0]  req_data,
    output logic [CPU_CORES-1:0]         resp_valid,
    output logic [DATA_W-1:0]            resp_data,
    output logic                         resp_shared,
    output logic [CPU_CORES-1:0]         snoop_valid,
    output logic [ADDR_W-1:0]            snoop_addr,
    output logic [1:0]                   snoop_type,
    input  logic [CPU_CORES-1:0]         snoop_hit,
    input  logic [CPU_CORES-1:0]         snoop_supply,
    input  logic [CPU_CORES*DATA_W-1:0]  snoop_data,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_write,
    output logic [ADDR_W-1:0]            mem_req_addr,
    output logic [DATA_W-1:0]            mem_req_data,
    input  logic                         mem_resp_valid,
    input  logic [DATA_W-1:0]            mem_resp_data
`ifdef SNOOP_BUS_STATS_EN
    ,
    output logic [15:0]                  txn_count,
    output logic [15:0]                  c2c_count
`endif
);

    localparam int GW = (CPU_CORES > 1) ? $clog2(CPU_CORES) : 1;

    typedef enum logic [1:0] {
        RD   = 2'd0,
        RDX  = 2'd1,
        UPGR = 2'd2,
        WB   = 2'd3
    } bus_req_t;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        SNOOP_RESP,
        MEM_RD,
        MEM_WAIT,
        MEM_WR,
        RESPOND
    } state_t;

    state_t              state, state_d;
    logic [GW-1:0]       last_grant, last_grant_d;
    logic [GW-1:0]       grant, grant_d;
    logic [ADDR_W-1:0]   addr_reg, addr_d;
    bus_req_t            type_reg, type_d;
    logic [DATA_W-1:0]   data_reg, data_d;
    logic                shared_reg, shared_d;

    logic [GW-1:0]       idx;
    logic [GW-1:0]       rr_pick;
    logic                rr_found;
    logic [CPU_CORES-1:0] grant_oh;
    logic [CPU_CORES-1:0] supply;
    logic [DATA_W-1:0]   supply_data;
    logic                txn_inc;
    logic                c2c_inc;

    // Search starts one past the last winner so every core gets a turn.
    always_comb begin
        idx      = last_grant;
        rr_pick  = '0;
        rr_found = 1'b0;
        for (int i = 0; i < CPU_CORES; i++) begin
            idx = (idx == GW'(CPU_CORES - 1)) ? '0 : idx + 1'b1;
            if (!rr_found && req_valid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = idx;
            end
        end
    end

    always_comb begin
        grant_oh        = '0;
        grant_oh[grant] = 1'b1;
    end

    // The requester's own hit/supply bits never count.
    assign supply = snoop_supply & ~grant_oh;

    always_comb begin
        supply_data = '0;
        for (int i = CPU_CORES - 1; i >= 0; i--) begin
            if (supply[i]) begin
                supply_data = snoop_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d       = state;
        last_grant_d  = last_grant;
        grant_d       = grant;
        addr_d        = addr_reg;
        type_d        = type_reg;
        data_d        = data_reg;
        shared_d      = shared_reg;
        req_ready     = '0;
        resp_valid    = '0;
        resp_data     = '0;
        resp_shared   = 1'b0;
        snoop_valid   = '0;
        snoop_addr    = '0;
        snoop_type    = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        txn_inc       = 1'b0;
        c2c_inc       = 1'b0;
        unique case (state)
            IDLE: begin
                if (rr_found) begin
                    req_ready[rr_pick] = reset_n;
                    txn_inc      = 1'b1;
                    grant_d      = rr_pick;
                    last_grant_d = rr_pick;
                    addr_d = req_addr[int'(rr_pick)*ADDR_W +: ADDR_W];
                    type_d = bus_req_t'(req_type[int'(rr_pick)*2 +: 2]);
                    data_d = req_data[int'(rr_pick)*DATA_W +: DATA_W];
                    state_d = (type_d == WB) ? MEM_WR : SNOOP;
                end
            end
            SNOOP: begin
                snoop_valid = ~grant_oh;
                snoop_addr  = addr_reg;
                snoop_type  = type_reg;
                state_d     = SNOOP_RESP;
            end
            SNOOP_RESP: begin
                shared_d = |(snoop_hit & ~grant_oh);
                if (type_reg == UPGR) begin
                    state_d = IDLE;
                end else if (|supply) begin
                    data_d  = supply_data;
                    c2c_inc = 1'b1;
                    state_d = RESPOND;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_reg;
                if (mem_req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    data_d  = mem_resp_data;
                    state_d = RESPOND;
                end
            end
            MEM_WR: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = addr_reg;
                mem_req_data  = data_reg;
                if (mem_req_ready) begin
                    state_d = IDLE;
                end
            end
            RESPOND: begin
                resp_valid[grant] = 1'b1;
                resp_data   = data_reg;
                resp_shared = (type_reg == RD) ? shared_reg : 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= GW'(CPU_CORES - 1);
            grant      <= '0;
            addr_reg   <= '0;
            type_reg   <= RD;
            data_reg   <= '0;
            shared_reg <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            grant      <= grant_d;
            addr_reg   <= addr_d;
            type_reg   <= type_d;
            data_reg   <= data_d;
            shared_reg <= shared_d;
        end
    end

`ifdef SNOOP_BUS_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txn_count <= '0;
            c2c_count <= '0;
        end else begin
            if (txn_inc && txn_count != 16'hFFFF) begin
                txn_count <= txn_count + 16'd1;
            end
            if (c2c_inc && c2c_count != 16'hFFFF) begin
                c2c_count <= c2c_count + 16'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = txn_inc ^ c2c_inc;
`endif

endmodule

// File: tb/tb_snoop_bus.sv
// tb_snoop_bus: randomized transactions against a transaction-level model
// of the snooping bus (round-robin order, data source, timing, reset abort).
module tb_snoop_bus;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 1;

    localparam logic [1:0] T_RD   = 2'd0;
    localparam logic [1:0] T_RDX  = 2'd1;
    localparam logic [1:0] T_UPGR = 2'd2;
    localparam logic [1:0] T_WB   = 2'd3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*2-1:0]    req_type;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_shared;
    logic [N-1:0]      snoop_valid;
    logic [AW-1:0]     snoop_addr;
    logic [1:0]        snoop_type;
    logic [N-1:0]      snoop_hit;
    logic [N-1:0]      snoop_supply;
    logic [N*DW-1:0]   snoop_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_data;
    logic              mem_resp_valid;
    logic [DW-1:0]     mem_resp_data;
`ifdef SNOOP_BUS_STATS_EN
    logic [15:0]       txn_count;
    logic [15:0]       c2c_count;
`endif

    snoop_bus #(.CPU_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_type      (req_type),
        .req_data      (req_data),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_shared   (resp_shared),
        .snoop_valid   (snoop_valid),
        .snoop_addr    (snoop_addr),
        .snoop_type    (snoop_type),
        .snoop_hit     (snoop_hit),
        .snoop_supply  (snoop_supply),
        .snoop_data    (snoop_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
`ifdef SNOOP_BUS_STATS_EN
        ,
        .txn_count     (txn_count),
        .c2c_count     (c2c_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: pending requests per core and the last winner.
    logic [N-1:0]  pend;
    logic [1:0]    p_type[N];
    logic [AW-1:0] p_addr[N];
    logic [DW-1:0] p_data[N];
    int            last;
    int            n_grants;
    int            n_c2c;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick();
        for (int i = 1; i <= N; i++) begin
            if (pend[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    function automatic logic [31:0] all_outs();
        return {1'b0, req_ready, resp_valid, resp_data, resp_shared,
                snoop_valid, snoop_addr, snoop_type, mem_req_valid,
                mem_req_write, mem_req_addr, mem_req_data};
    endfunction

    task automatic idle_inputs();
        snoop_hit      = '0;
        snoop_supply   = '0;
        snoop_data     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = DW'($urandom);
    endtask

    task automatic drive_reqs();
        req_valid = pend;
        for (int c = 0; c < N; c++) begin
            req_addr[c*AW +: AW] = p_addr[c];
            req_type[c*2 +: 2]   = p_type[c];
            req_data[c*DW +: DW] = p_data[c];
        end
    endtask

    // One complete bus transaction; the bus is idle on the first cycle.
    task automatic serve(input logic [N-1:0] hit, input logic [N-1:0] sup,
                         input logic [N-1:0] sdat, input int rdly,
                         input int mdly, input logic [DW-1:0] mdat,
                         output logic [N-1:0] got_ready);
        int g;
        logic [N-1:0] oh, s;
        logic [1:0] t;
        logic [AW-1:0] a;
        logic [DW-1:0] d, cdat;
        logic shr;
        g  = pick();
        oh = N'(1) << g;
        t  = p_type[g];
        a  = p_addr[g];
        d  = p_data[g];
        cyc();
        idle_inputs();
        drive_reqs();
        #1;
        got_ready = req_ready;
        check("grant", {28'd0, req_ready}, {28'd0, oh});
        check("no_resp_idle", {28'd0, resp_valid}, 32'd0);
        pend[g] = 1'b0;
        last = g;
        n_grants++;
        if (t == T_WB) begin
            for (int k = 0; k <= rdly; k++) begin
                cyc();
                drive_reqs();
                mem_req_ready  = (k == rdly);
                mem_resp_valid = (k < rdly) ? 1'($urandom) : 1'b0;
                #1;
                check("wb_req", {mem_req_valid, mem_req_write,
                      mem_req_addr, mem_req_data},
                      {1'b1, 1'b1, a, d});
                check("wb_busy", {req_ready, resp_valid, snoop_valid},
                      32'd0);
            end
            return;
        end
        cyc();
        drive_reqs();
        #1;
        check("snoop", {snoop_valid, snoop_addr, snoop_type},
              {~oh, a, t});
        check("snoop_busy", {req_ready, mem_req_valid}, 32'd0);
        cyc();
        snoop_hit    = hit;
        snoop_supply = sup;
        snoop_data   = sdat;
        #1;
        check("snoop_once", {snoop_valid, resp_valid}, 32'd0);
        s   = sup & ~oh;
        shr = |(hit & ~oh);
        cdat = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (s[i]) cdat = sdat[i*DW +: DW];
        end
        if (t == T_UPGR) return;
        if (s != '0) begin
            n_c2c++;
            cyc();
            idle_inputs();
            #1;
            check("c2c_resp", {resp_valid, resp_data, resp_shared,
                  mem_req_valid},
                  {oh, cdat, (t == T_RD) ? shr : 1'b0, 1'b0});
            return;
        end
        for (int k = 0; k <= rdly; k++) begin
            cyc();
            idle_inputs();
            mem_req_ready  = (k == rdly);
            mem_resp_valid = (k < rdly) ? 1'($urandom) : 1'b0;
            #1;
            check("rd_req", {mem_req_valid, mem_req_write, mem_req_addr,
                  resp_valid}, {1'b1, 1'b0, a, 4'd0});
        end
        for (int k = 0; k <= mdly; k++) begin
            cyc();
            idle_inputs();
            mem_resp_valid = (k == mdly);
            mem_resp_data  = (k == mdly) ? mdat : ~mdat;
            #1;
            check("rd_wait", {mem_req_valid, resp_valid}, 32'd0);
        end
        cyc();
        idle_inputs();
        #1;
        check("mem_resp", {resp_valid, resp_data, resp_shared},
              {oh, mdat, (t == T_RD) ? shr : 1'b0});
    endtask

    initial begin
        logic [N-1:0] got;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        last = N - 1;
        n_grants = 0;
        n_c2c = 0;
        pend = '0;
        for (int c = 0; c < N; c++) begin
            p_type[c] = T_RD;
            p_addr[c] = '0;
            p_data[c] = '0;
        end
        reset_n = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_type = '0;
        req_data = '0;
        idle_inputs();
        repeat (3) cyc();
        req_valid = 4'hF;
        #1;
        check("reset_outs", all_outs(), 32'd0);
        req_valid = '0;
        reset_n = 1'b1;

        // All four cores request continuously.
        pend = 4'hF;
        for (int k = 0; k < 5; k++) begin
            serve('0, '0, '0, 0, 0, 1'b1, got);
            check("rr_order", {28'd0, got}, 32'd1 << exp_order[k]);
            pend = 4'hF;
        end
        pend = '0;

        // Core 1 RD from L2.
        pend[1] = 1'b1;
        p_type[1] = T_RD;
        p_addr[1] = 6'h2A;
        serve('0, '0, '0, 1, 2, 1'b1, got);

        // Core 0 RD supplied by core 2.
        pend[0] = 1'b1;
        p_type[0] = T_RD;
        p_addr[0] = 6'h05;
        serve(4'b0100, 4'b0100, 4'b0100, 0, 0, 1'b0, got);

        // Core 3 UPGR, then core 0 is granted at T+3.
        pend[3] = 1'b1;
        p_type[3] = T_UPGR;
        p_addr[3] = 6'h19;
        serve(4'b0001, '0, '0, 0, 0, 1'b0, got);
        pend[0] = 1'b1;
        p_type[0] = T_RDX;
        serve(4'b1110, 4'b0010, 4'b0010, 0, 0, 1'b0, got);

        // Core 2 WB stalled 5 cycles, then core 1 right after.
        pend[2] = 1'b1;
        p_type[2] = T_WB;
        p_addr[2] = 6'h11;
        p_data[2] = 1'b1;
        serve('0, '0, '0, 5, 0, 1'b0, got);
        pend[1] = 1'b1;
        p_type[1] = T_RD;
        serve('0, 4'b1111, 4'b0110, 0, 0, 1'b0, got);

        for (int r = 0; r < 200; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    pend[c]   = 1'b1;
                    p_type[c] = 2'($urandom);
                    p_addr[c] = AW'($urandom);
                    p_data[c] = DW'($urandom);
                end else if (pend[c] && $urandom_range(0, 7) == 0) begin
                    pend[c] = 1'b0;
                end
            end
            if (pend == '0) pend[$urandom_range(0, N - 1)] = 1'b1;
            serve(N'($urandom), N'($urandom), N'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  DW'($urandom), got);
        end

`ifdef SNOOP_BUS_STATS_EN
        check("txn_count", {16'd0, txn_count}, n_grants);
        check("c2c_count", {16'd0, c2c_count}, n_c2c);
`endif

        // Reset while waiting on L2.
        pend = '0;
        pend[0] = 1'b1;
        p_type[0] = T_RD;
        p_addr[0] = 6'h33;
        cyc();
        idle_inputs();
        drive_reqs();
        pend = '0;
        cyc();
        drive_reqs();
        cyc();
        cyc();
        mem_req_ready = 1'b1;
        #1;
        check("rst_pre_req", {31'd0, mem_req_valid}, 32'd1);
        cyc();
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_abort", all_outs(), 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        last = N - 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            mem_resp_valid = (k == 0);
            mem_resp_data  = 1'b1;
            #1;
            check("rst_late_resp", all_outs(), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
